hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 34: cycles mult_ctrl is held high before the multiplier result is captured.
REQ-002 SHALL have parameter DIV_LAT, default 34: cycles div_ctrl is held high before the divider result is captured.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port op_start, input, 1 bit: request to start a multiply or divide.
REQ-006 SHALL have port op_sel, input, 1 bit: 0 selects MULT, 1 selects DIV.
REQ-007 SHALL have ports rs_val and rt_val, input, 32 bits each: operands (multiplicand/multiplier, dividend/divisor).
REQ-008 SHALL have ports hi_wr and lo_wr, input, 1 bit each: MTHI/MTLO write strobes.
REQ-009 SHALL have port wr_data, input, 32 bits: MTHI/MTLO write data.
REQ-010 SHALL have ports op_a and op_b, output, 32 bits each: registered operands fed to the multiplier/divider in0/in1.
REQ-011 SHALL have ports mult_ctrl and div_ctrl, output, 1 bit each: control levels to the multiplier and divider; low clears them.
REQ-012 SHALL have ports mult_hi_in and mult_lo_in, input, 32 bits each: multiplier product high and low words.
REQ-013 SHALL have ports div_hi_in and div_lo_in, input, 32 bits each: divider remainder and quotient.
REQ-014 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.
REQ-015 SHALL have ports busy, done and div_zero, output, 1 bit each: operation in flight; one-cycle completion pulse; one-cycle divide-by-zero pulse.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN_MUL and RUN_DIV, using a 6-bit cycle counter.
REQ-017 In IDLE, op_start=1 with op_sel=0 SHALL latch rs_val/rt_val into op_a/op_b, clear the counter and enter RUN_MUL.
REQ-018 In IDLE, op_start=1 with op_sel=1 and rt_val!=0 SHALL latch the operands the same way and enter RUN_DIV.
REQ-019 In IDLE, op_start=1 with op_sel=1 and rt_val==0 SHALL pulse div_zero for one cycle, stay in IDLE, and leave HI/LO, op_a and op_b unchanged.
REQ-020 mult_ctrl SHALL be high exactly while in RUN_MUL, and div_ctrl exactly while in RUN_DIV; both SHALL never be high together.
REQ-021 In RUN_x the counter SHALL increment every cycle.
REQ-022 At the edge where the counter equals LAT-1, the block SHALL load hi/lo from x_hi_in/x_lo_in, set done=1 for one cycle and return to IDLE.
REQ-023 Latency from the op_start sampling edge to hi/lo update and done SHALL be LAT+1 edges, independent of operand values.
REQ-024 busy SHALL be 1 in every RUN_x cycle and 0 in IDLE, including the done cycle.
REQ-025 op_start while busy SHALL be ignored, with no queuing.
REQ-026 op_start in the done cycle SHALL be accepted as a new operation.
REQ-027 op_a and op_b SHALL hold stable throughout RUN_x.
REQ-028 hi_wr/lo_wr in IDLE SHALL load wr_data into hi/lo on the next edge; asserting both together SHALL write both.
REQ-029 hi_wr/lo_wr while busy SHALL be ignored.
REQ-030 If hi_wr/lo_wr and an accepted op_start occur in the same IDLE cycle, op_start SHALL win and the write SHALL be dropped.
REQ-031 hi and lo SHALL change only on a capture (REQ-022), an accepted write (REQ-028) or reset.

Reset
REQ-032 When reset=0 at a rising edge: state=IDLE, counter=0, hi=lo=op_a=op_b=0, mult_ctrl=div_ctrl=busy=done=div_zero=0.
REQ-033 Reset mid-operation SHALL abort the operation with no capture and deassert the ctrl level on that same edge, so the downstream unit clears.
REQ-034 All other inputs SHALL be ignored during reset.

Structure
REQ-035 The FSM state encoding, the op_sel encodings (OP_MULT=0, OP_DIV=1) and the default latency constants SHALL live in a shared package, hilo_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the multiplier and divider are instantiated beside it by the datapath, not inside it.

Verification
REQ-037 MULT: rs=7, rt=0xFFFFFFFD (-3), behavioural multiplier model -> done at edge 35, hi=0xFFFFFFFF, lo=0xFFFFFFEB, mult_ctrl high for exactly 34 cycles.
REQ-038 DIV: rs=100, rt=7 -> done at edge DIV_LAT+1, lo=0x0000000E, hi=0x00000002.
REQ-039 DIV by zero: rs=5, rt=0 with hi=0x11, lo=0x22 preloaded -> div_zero one cycle, busy never rises, hi/lo unchanged.
REQ-040 Busy writes: hi_wr with wr_data=0xDEADBEEF at cycle 10 of a MULT -> ignored; hi holds the product after done.
REQ-041 Reset=0 at cycle 12 of a DIV -> div_ctrl low next cycle, hi=lo=0, no done pulse.
REQ-042 Back-to-back: a second MULT (rs=2, rt=3) asserted in the done cycle -> accepted; hi=0, lo=6 after a further 35 edges.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO register unit: FSM encoding, operation
// select encodings and the default multiplier/divider latencies.
package hilo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN_MUL = 2'd1,
    ST_RUN_DIV = 2'd2
  } hilo_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_MULT_LAT = 34;
  localparam int DEF_DIV_LAT  = 34;
  localparam int CNT_W        = 6;

  // Counter value seen on the capture edge for a given latency.
  function automatic logic [CNT_W-1:0] last_count(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with sequencing of an external multi-cycle
// multiplier and divider; also handles MTHI/MTLO writes and divide-by-zero.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_start,
  input  logic        op_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        hi_wr,
  input  logic        lo_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        mult_ctrl,
  output logic        div_ctrl,
  input  logic [31:0] mult_hi_in,
  input  logic [31:0] mult_lo_in,
  input  logic [31:0] div_hi_in,
  input  logic [31:0] div_lo_in,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  localparam logic [CNT_W-1:0] MULT_LAST = last_count(MULT_LAT);
  localparam logic [CNT_W-1:0] DIV_LAST  = last_count(DIV_LAT);

  hilo_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_div_by_zero;

  assign w_div_by_zero = (op_sel == OP_DIV) && (rt_val == 32'd0);

  // ctrl levels and busy are registered alongside the state, so dropping to
  // IDLE (capture or reset) lowers them on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      mult_ctrl <= 1'b0;
      div_ctrl  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_start) begin
            // A rejected divide still consumes the cycle: any write is dropped.
            if (w_div_by_zero) begin
              div_zero <= 1'b1;
            end else begin
              op_a  <= rs_val;
              op_b  <= rt_val;
              r_cnt <= '0;
              busy  <= 1'b1;
              if (op_sel == OP_MULT) begin
                r_state   <= ST_RUN_MUL;
                mult_ctrl <= 1'b1;
              end else begin
                r_state  <= ST_RUN_DIV;
                div_ctrl <= 1'b1;
              end
            end
          end else begin
            if (hi_wr) hi <= wr_data;
            if (lo_wr) lo <= wr_data;
          end
        end
        ST_RUN_MUL: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == MULT_LAST) begin
            hi        <= mult_hi_in;
            lo        <= mult_lo_in;
            done      <= 1'b1;
            busy      <= 1'b0;
            mult_ctrl <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RUN_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == DIV_LAST) begin
            hi       <= div_hi_in;
            lo       <= div_lo_in;
            done     <= 1'b1;
            busy     <= 1'b0;
            div_ctrl <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          busy      <= 1'b0;
          mult_ctrl <= 1'b0;
          div_ctrl  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit with behavioural signed multiplier/divider
// models driven from the registered operands.
module tb_hilo_unit;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_start = 1'b0;
  logic        op_sel = 1'b0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] op_a, op_b, hi, lo;
  logic        mult_ctrl, div_ctrl, busy, done, div_zero;
  logic [31:0] mult_hi_in, mult_lo_in, div_hi_in, div_lo_in;

  logic signed [63:0] w_prod;
  logic signed [31:0] w_sa, w_sb;

  assign w_sa   = op_a;
  assign w_sb   = op_b;
  assign w_prod = $signed({{32{op_a[31]}}, op_a}) * $signed({{32{op_b[31]}}, op_b});
  assign mult_hi_in = w_prod[63:32];
  assign mult_lo_in = w_prod[31:0];
  assign div_lo_in  = (op_b == 32'd0) ? 32'd0 : 32'(w_sa / w_sb);
  assign div_hi_in  = (op_b == 32'd0) ? 32'd0 : 32'(w_sa % w_sb);

  hilo_unit dut (
    .clk        (clk),
    .reset      (reset),
    .op_start   (op_start),
    .op_sel     (op_sel),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .hi_wr      (hi_wr),
    .lo_wr      (lo_wr),
    .wr_data    (wr_data),
    .op_a       (op_a),
    .op_b       (op_b),
    .mult_ctrl  (mult_ctrl),
    .div_ctrl   (div_ctrl),
    .mult_hi_in (mult_hi_in),
    .mult_lo_in (mult_lo_in),
    .div_hi_in  (div_hi_in),
    .div_lo_in  (div_lo_in),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  int          edges, ctrl_cnt;
  bit          both_hi;
  logic [31:0] hi1, lo1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic sel, input logic [31:0] a, input logic [31:0] b);
    op_start = 1'b1;
    op_sel   = sel;
    rs_val   = a;
    rt_val   = b;
  endtask

  // Clocks until done (or budget), counting edges from the op_start sampling
  // edge and the cycles any ctrl level is seen high. Optional mid-run pokes.
  task automatic wait_done(input int budget, input int wr_edge, input int st_edge,
                           output int n_edges, output int n_ctrl, output bit both,
                           output logic [31:0] h1, output logic [31:0] l1);
    n_edges = 0;
    n_ctrl  = 0;
    both    = 1'b0;
    h1      = '0;
    l1      = '0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (n == 1) begin
        h1 = hi;
        l1 = lo;
      end
      op_start = 1'b0;
      hi_wr    = 1'b0;
      lo_wr    = 1'b0;
      if (n == wr_edge) begin
        hi_wr   = 1'b1;
        wr_data = 32'hDEADBEEF;
      end
      if (n == st_edge) start_op(OP_DIV, 32'd55, 32'd66);
      if (mult_ctrl || div_ctrl) n_ctrl++;
      if (mult_ctrl && div_ctrl) both = 1'b1;
      if (done) begin
        n_edges = n;
        break;
      end
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_op_a", op_a, 32'd0);
    check("rst_op_b", op_b, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_div_zero", 32'(div_zero), 32'd0);
    check("rst_mult_ctrl", 32'(mult_ctrl), 32'd0);
    check("rst_div_ctrl", 32'(div_ctrl), 32'd0);
    reset = 1'b1;
    tick();

    // MULT 7 * -3, busy write at cycle 10, busy op_start at cycle 20
    start_op(OP_MULT, 32'd7, 32'hFFFFFFFD);
    wait_done(100, 10, 20, edges, ctrl_cnt, both_hi, hi1, lo1);
    check("mul_done_edge", 32'(edges), 32'd35);
    check("mul_ctrl_cycles", 32'(ctrl_cnt), 32'd34);
    check("mul_hi", hi, 32'hFFFFFFFF);
    check("mul_lo", lo, 32'hFFFFFFEB);
    check("mul_busy_done_cyc", 32'(busy), 32'd0);
    check("mul_ctrl_done_cyc", 32'(mult_ctrl), 32'd0);
    check("mul_op_a_stable", op_a, 32'd7);
    check("mul_op_b_stable", op_b, 32'hFFFFFFFD);
    check("mul_no_overlap", 32'(both_hi), 32'd0);

    // Back-to-back MULT 2 * 3 started in the done cycle
    start_op(OP_MULT, 32'd2, 32'd3);
    wait_done(100, 0, 0, edges, ctrl_cnt, both_hi, hi1, lo1);
    check("b2b_done_edge", 32'(edges), 32'd35);
    check("b2b_hi", hi, 32'd0);
    check("b2b_lo", lo, 32'd6);
    tick();
    check("b2b_done_one_cycle", 32'(done), 32'd0);
    check("b2b_idle_busy", 32'(busy), 32'd0);

    // MTHI/MTLO in IDLE
    hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h33;
    tick();
    hi_wr = 1'b0; lo_wr = 1'b0;
    check("wr_both_hi", hi, 32'h33);
    check("wr_both_lo", lo, 32'h33);
    hi_wr = 1'b1; wr_data = 32'h11;
    tick();
    hi_wr = 1'b0;
    check("wr_hi_only_hi", hi, 32'h11);
    check("wr_hi_only_lo", lo, 32'h33);
    lo_wr = 1'b1; wr_data = 32'h22;
    tick();
    lo_wr = 1'b0;
    check("wr_lo_only_lo", lo, 32'h22);
    check("wr_lo_only_hi", hi, 32'h11);

    // Divide by zero, with a write in the same cycle
    start_op(OP_DIV, 32'd5, 32'd0);
    hi_wr = 1'b1; wr_data = 32'h99;
    tick();
    op_start = 1'b0; hi_wr = 1'b0;
    check("dz_pulse", 32'(div_zero), 32'd1);
    check("dz_busy", 32'(busy), 32'd0);
    check("dz_div_ctrl", 32'(div_ctrl), 32'd0);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    check("dz_op_a", op_a, 32'd2);
    check("dz_op_b", op_b, 32'd3);
    tick();
    check("dz_pulse_one_cycle", 32'(div_zero), 32'd0);
    check("dz_busy_after", 32'(busy), 32'd0);

    // DIV 100 / 7 with a conflicting lo write on the start cycle
    start_op(OP_DIV, 32'd100, 32'd7);
    lo_wr = 1'b1; wr_data = 32'hBAD;
    wait_done(100, 0, 0, edges, ctrl_cnt, both_hi, hi1, lo1);
    check("div_start_drops_wr", lo1, 32'h22);
    check("div_done_edge", 32'(edges), 32'd35);
    check("div_ctrl_cycles", 32'(ctrl_cnt), 32'd34);
    check("div_hi_rem", hi, 32'd2);
    check("div_lo_quot", lo, 32'h0000000E);
    check("div_busy_done_cyc", 32'(busy), 32'd0);
    check("div_ctrl_done_cyc", 32'(div_ctrl), 32'd0);

    // Reset at cycle 12 of a DIV
    start_op(OP_DIV, 32'd100, 32'd7);
    wait_done(12, 0, 0, edges, ctrl_cnt, both_hi, hi1, lo1);
    check("rdiv_no_early_done", 32'(edges), 32'd0);
    check("rdiv_ctrl_before", 32'(div_ctrl), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rdiv_ctrl_low", 32'(div_ctrl), 32'd0);
    check("rdiv_busy", 32'(busy), 32'd0);
    check("rdiv_hi", hi, 32'd0);
    check("rdiv_lo", lo, 32'd0);
    check("rdiv_done", 32'(done), 32'd0);
    check("rdiv_op_a", op_a, 32'd0);
    wait_done(40, 0, 0, edges, ctrl_cnt, both_hi, hi1, lo1);
    check("rdiv_no_done_after", 32'(edges), 32'd0);
    check("rdiv_no_ctrl_after", 32'(ctrl_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
